result_select_pipe: RTL and testbench
=====================================

# result_select_pipe

Parametrised, registered successor to the CPU's combinational result multiplexers. It selects one of NUM_IN result channels, either by a directed select index or by round-robin arbitration, and presents it through a one-entry output register. A valid/ready handshake on every side lets writeback and execute-unit results be merged without dropped or duplicated transfers.

## Interface

Parameters:
- N, 32, data width of each channel and of the output.
- NUM_IN, 8, number of input channels; legal range 2..64.
- SEL_W, derived localparam = $clog2(NUM_IN); not overridable.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*N  packed channel data; channel i occupies bits [i*N+N-1 : i*N].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready; at most one bit set per cycle.
- mode  input  1  0 = directed (use sel), 1 = round-robin.
- sel  input  SEL_W  channel index used in directed mode.
- out_data  output  N  registered selected data.
- out_sel  output  SEL_W  index of the channel held in the output register.
- out_valid  output  1  output register holds a transfer.
- out_ready  input  1  downstream accepts the output this cycle.

## Operation

- accept_en = !out_valid || out_ready. This gives combinational pass-through of downstream ready, with no bubble on back-to-back transfers.
- Directed mode (mode=0):
  - Grant = sel when sel < NUM_IN and in_valid[sel] = 1.
  - Otherwise there is no grant. An out-of-range sel produces no grant, never X/Z.
- Round-robin mode (mode=1):
  - Grant = the first i with in_valid[i] = 1, searching ptr, ptr+1, …, NUM_IN-1, 0, …, ptr-1 (wrap-around).
  - No grant if in_valid is all zero.
- in_ready[g] = accept_en && grant exists && g = granted index. All other in_ready bits are 0.
- Transfer on channel g occurs when in_valid[g] && in_ready[g]. On that clk edge:
  - out_data <= channel g data.
  - out_sel <= g.
  - out_valid <= 1.
- Output drain: when out_valid && out_ready and no new transfer occurs, out_valid <= 0. out_data and out_sel hold their last value.
- Hold: while out_valid && !out_ready, out_data and out_sel are stable and no input is accepted.
- Round-robin pointer ptr (SEL_W bits):
  - Updates only on a round-robin-mode transfer: ptr <= (g == NUM_IN-1) ? 0 : g+1.
  - Holds in directed mode and when no transfer occurs. Mode switches do not reset it.
- Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_sel=0, ptr=0.
  - in_ready is 0 for every bit while rst is high.
  - Reset mid-transfer discards the held output; nothing is replayed.

## Timing

- Latency 1 cycle: a transfer accepted at edge k appears on out_data/out_valid after edge k.
- Throughput: 1 transfer per cycle while out_ready stays high.
- in_ready depends combinationally on in_valid, mode, sel, out_valid and out_ready. Inputs must not depend combinationally on in_ready.
- Simultaneous drain and accept in the same cycle: the output register is replaced and out_valid stays 1.
- mode and sel are sampled every cycle. A change takes effect on the next grant decision with no extra latency.
- Upstream must hold in_valid and in_data until its in_ready is seen. The block does not assume this for correctness of the other channels.

## Test plan

- Reset then directed: rst 2 cycles → all outputs 0. Then mode=0, sel=3, in_valid=8'h08, ch3=32'hDEADBEEF, out_ready=1 → in_ready=8'h08; next cycle out_valid=1, out_data=DEADBEEF, out_sel=3.
- Directed, invalid target: sel=5, in_valid=8'h08 → in_ready=0 and out_valid stays 0. Repeat with NUM_IN=6 and sel=7 → no grant, no X on any output.
- Round-robin fairness: mode=1, in_valid=8'hFF held, out_ready=1 for 10 cycles → out_sel sequence 0,1,…,7,0,1; ptr wraps from 7 to 0.
- Backpressure: out_valid=1 with ch2 data 32'h1234, out_ready=0 for 3 cycles with other channels valid → out_data/out_sel stable and in_ready=0. Raise out_ready → same-cycle accept of the next grant; out_valid remains 1.
- Round-robin skip: ptr=6, in_valid=8'h05 → grants ch0 then ch2 on consecutive cycles, ptr ends at 3. Switching to mode=0 with sel=0 leaves ptr=3.
- Reset mid-operation: rst asserted while out_valid=1 and out_ready=0 → next cycle out_valid=0, out_data=0, ptr=0, and in_ready=0 during reset.

Source files
------------

// File: rtl/result_select_pipe.sv
// result_select_pipe: picks one of NUM_IN valid/ready result channels, either
// by a directed index or by round-robin, and registers it in a one-entry
// output stage. The output stage can drain and refill in the same cycle, so
// back-to-back transfers run without bubbles.
module result_select_pipe #(
  parameter int N      = 32,
  parameter int NUM_IN = 8,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IN*N-1:0] in_data,
  input  logic [NUM_IN-1:0]   in_valid,
  output logic [NUM_IN-1:0]   in_ready,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  output logic [N-1:0]        out_data,
  output logic [SEL_W-1:0]    out_sel,
  output logic                out_valid,
  input  logic                out_ready
);

  // Output register and round-robin pointer state.
  logic [N-1:0]     out_data_reg;
  logic [SEL_W-1:0] out_sel_reg;
  logic             out_valid_reg;
  logic [SEL_W-1:0] ptr_reg;
  logic [SEL_W-1:0] ptr_next;

  // Grant decision.
  logic             accept_en;
  logic             dir_in_range;
  logic             dir_hit;
  logic             rr_hit;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W:0]   rr_pos;
  logic             grant_ok;
  logic [SEL_W-1:0] grant_idx;
  logic             xfer;

  // Per-channel view of the packed input bus.
  logic [N-1:0] ch_data [NUM_IN];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_chan
      assign ch_data[gi] = in_data[gi*N +: N];
      // Only the granted channel sees ready; everything is held off in reset.
      assign in_ready[gi] = !rst && xfer && (grant_idx == SEL_W'(gi));
    end
  endgenerate

  // The output stage can take a new item if it is empty or being drained now.
  assign accept_en = !out_valid_reg || out_ready;

  // Directed select: an index past the last channel never grants, and the
  // in_valid lookup is masked so a non-power-of-two NUM_IN cannot produce X.
  assign dir_in_range = ({1'b0, sel} < (SEL_W+1)'(NUM_IN));
  assign dir_hit      = dir_in_range ? in_valid[sel] : 1'b0;

  // Round-robin search starting at ptr_reg with wrap-around; scanning from the
  // farthest offset down leaves the nearest valid channel as the winner.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    rr_pos = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      rr_pos = {1'b0, ptr_reg} + (SEL_W+1)'(k);
      if (rr_pos >= (SEL_W+1)'(NUM_IN)) begin
        rr_pos = rr_pos - (SEL_W+1)'(NUM_IN);
      end
      if (in_valid[rr_pos[SEL_W-1:0]]) begin
        rr_hit = 1'b1;
        rr_idx = rr_pos[SEL_W-1:0];
      end
    end
  end

  // Merge the two selection modes into one grant.
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = '0;
    if (mode) begin
      grant_ok  = rr_hit;
      grant_idx = rr_idx;
    end else begin
      grant_ok  = dir_hit;
      grant_idx = sel;
    end
  end

  // A grant always has in_valid set, so grant plus room means a transfer.
  assign xfer = grant_ok && accept_en;

  // Next round-robin start point is the channel just after the winner.
  assign ptr_next = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + SEL_W'(1);

  // Output register load/drain and pointer advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      ptr_reg       <= '0;
    end else begin
      if (xfer) begin
        out_data_reg  <= ch_data[grant_idx];
        out_sel_reg   <= grant_idx;
        out_valid_reg <= 1'b1;
        if (mode) begin
          ptr_reg <= ptr_next;
        end
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_result_select_pipe.sv
// Scoreboard bench for result_select_pipe: the driver predicts each grant from
// a queue-level model and pushes the expected output; an independent monitor
// pops and compares whenever the DUT hands an output downstream.
module tb_result_select_pipe;

  localparam int NUM = 8;
  localparam int W   = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NUM*W-1:0] in_data;
  logic [NUM-1:0]   in_valid;
  logic [NUM-1:0]   in_ready;
  logic             mode;
  logic [2:0]       sel;
  logic [W-1:0]     out_data;
  logic [2:0]       out_sel;
  logic             out_valid;
  logic             out_ready;

  // Second instance with a non-power-of-two channel count.
  logic [6*W-1:0]   in_data6;
  logic [5:0]       in_valid6;
  logic [5:0]       in_ready6;
  logic             mode6;
  logic [2:0]       sel6;
  logic [W-1:0]     out_data6;
  logic [2:0]       out_sel6;
  logic             out_valid6;
  logic             out_ready6;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] d;
    logic [2:0]   s;
  } exp_t;

  exp_t exp_q[$];
  bit   mdl_full = 1'b0;
  int   mdl_ptr  = 0;
  bit   prev_rst = 1'b0;

  always #5 clk = ~clk;

  result_select_pipe #(.N(W), .NUM_IN(NUM)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
  );

  result_select_pipe #(.N(W), .NUM_IN(6)) dut6 (
    .clk(clk), .rst(rst), .in_data(in_data6), .in_valid(in_valid6),
    .in_ready(in_ready6), .mode(mode6), .sel(sel6), .out_data(out_data6),
    .out_sel(out_sel6), .out_valid(out_valid6), .out_ready(out_ready6)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle: drive inputs, check combinational ready and occupancy, predict.
  task automatic step(input logic r, input logic m, input logic [2:0] s,
                      input logic [NUM-1:0] v, input logic ordy,
                      input bit fix3, input logic [W-1:0] d3);
    int  g;
    bit  found;
    logic [NUM-1:0] exp_ready;
    @(negedge clk);
    rst = r; mode = m; sel = s; in_valid = v; out_ready = ordy;
    for (int c = 0; c < NUM; c++) in_data[c*W +: W] = $urandom;
    if (fix3) in_data[3*W +: W] = d3;
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, mdl_full});
    if (prev_rst) begin
      chk("reset_out_data", {32'd0, out_data}, 64'd0);
      chk("reset_out_sel", {61'd0, out_sel}, 64'd0);
    end
    g = -1;
    if (!r && (!mdl_full || ordy)) begin
      if (!m) begin
        if (int'(s) < NUM && v[s]) g = int'(s);
      end else begin
        found = 1'b0;
        for (int k = 0; k < NUM; k++) begin
          if (!found && v[(mdl_ptr + k) % NUM]) begin
            g = (mdl_ptr + k) % NUM;
            found = 1'b1;
          end
        end
      end
    end
    exp_ready = (g >= 0) ? (NUM'(1) << g) : '0;
    chk(r ? "in_ready_in_reset" : "in_ready", {56'd0, in_ready}, {56'd0, exp_ready});
    if (r) begin
      exp_q.delete();
      mdl_full = 1'b0;
      mdl_ptr  = 0;
    end else if (g >= 0) begin
      exp_q.push_back('{d: in_data[g*W +: W], s: 3'(g)});
      mdl_full = 1'b1;
      if (m) mdl_ptr = (g + 1) % NUM;
    end else if (ordy) begin
      mdl_full = 1'b0;
    end
    prev_rst = r;
  endtask

  // Monitor: every downstream handshake retires the oldest expected item.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got data %h sel %0d, expected none", out_data, out_sel);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", {32'd0, out_data}, {32'd0, e.d});
          chk("out_sel", {61'd0, out_sel}, {61'd0, e.s});
        end
      end
    end
  end

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0; in_data = '0;
    in_data6 = '0; in_valid6 = '0; mode6 = 1'b0; sel6 = '0; out_ready6 = 1'b1;

    // Reset for two cycles, then the directed example.
    step(1, 0, 0, 8'h00, 0, 0, '0);
    step(1, 0, 0, 8'h00, 0, 0, '0);
    step(0, 0, 3, 8'h08, 1, 1, 32'hDEADBEEF);
    step(0, 0, 5, 8'h08, 1, 0, '0);   // target not valid: no grant
    step(0, 0, 5, 8'h08, 1, 0, '0);

    // Round-robin fairness with every channel valid.
    for (int i = 0; i < 10; i++) step(0, 1, 0, 8'hFF, 1, 0, '0);

    // Backpressure with ch2 held, then same-cycle drain and accept.
    step(0, 0, 2, 8'h04, 1, 0, '0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'hFF, 0, 0, '0);
    step(0, 1, 0, 8'hFF, 1, 0, '0);
    step(0, 1, 0, 8'h00, 1, 0, '0);

    // Round-robin skip: move ptr to 6, grant ch0 then ch2, then directed ch0.
    step(0, 1, 0, 8'h20, 1, 0, '0);
    step(0, 1, 0, 8'h05, 1, 0, '0);
    step(0, 1, 0, 8'h05, 1, 0, '0);
    step(0, 0, 0, 8'h01, 1, 0, '0);
    step(0, 1, 0, 8'hFF, 1, 0, '0);   // pointer must still be 3

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), 3'($urandom),
           8'($urandom & $urandom), ($urandom_range(0, 9) < 7), 0, '0);
    end

    // Reset while an output is held under backpressure.
    step(0, 1, 0, 8'hFF, 0, 0, '0);
    step(0, 1, 0, 8'hFF, 0, 0, '0);
    step(1, 1, 0, 8'hFF, 0, 0, '0);
    step(0, 1, 0, 8'hFF, 1, 0, '0);   // pointer back to 0: expect ch0
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 1, 0, '0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // Six-channel instance: out-of-range select never grants, in-range does.
    @(negedge clk);
    mode6 = 1'b0; sel6 = 3'd7; in_valid6 = 6'h3F; in_data6 = {6{32'hA5A5_0001}};
    #1;
    chk("n6_ready_oob", {58'd0, in_ready6}, 64'd0);
    @(negedge clk);
    #1;
    chk("n6_valid_oob", {63'd0, out_valid6}, 64'd0);
    chk("n6_no_x", {63'd0, $isunknown({in_ready6, out_data6, out_sel6, out_valid6})}, 64'd0);
    sel6 = 3'd5;
    #1;
    chk("n6_ready_sel5", {58'd0, in_ready6}, 64'h20);
    @(negedge clk);
    #1;
    chk("n6_sel_sel5", {61'd0, out_sel6}, 64'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
